alu_share_arb: RTL and testbench
================================

// Module: alu_share_arb
// PURPOSE
//  Shares one combinational RV32 ALU (fnc3/fnc1/rs1/rs2 -> rd) between two requesters.
//  Requester 0 is the main execute stage; requester 1 is the address/auxiliary unit.
//  Two-stage pipe: ISS register drives the ALU, WB register holds the tagged result.
//  Full throughput, valid/ready backpressure on every port; opcodes come from Opcode.vh.
// PARAMETERS
//  XLEN   32  operand/result width
//  CNT_W  16  width of the per-requester grant counters
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  rst          in   1      synchronous, active-high reset
//  req0_valid   in   1      requester 0 has an operation
//  req0_ready   out  1      requester 0 operation accepted this cycle when valid&ready
//  req0_fnc3    in   3      funct3 (FNC_* encodings)
//  req0_fnc1    in   1      funct7[5] (FNC2_ADD/SUB, FNC2_SRL/SRA)
//  req0_rs1     in   XLEN   operand A
//  req0_rs2     in   XLEN   operand B
//  req1_*       -    -      identical set for requester 1
//  alu_fnc3     out  3      to ALU, from ISS register
//  alu_fnc1     out  1      to ALU, from ISS register
//  alu_rs1      out  XLEN   to ALU, from ISS register
//  alu_rs2      out  XLEN   to ALU, from ISS register
//  alu_rd       in   XLEN   ALU combinational result
//  rsp_valid    out  1      WB register holds a result
//  rsp_ready    in   1      consumer takes result when valid&ready
//  rsp_id       out  1      requester that issued the result
//  rsp_rd       out  XLEN   result
//  gnt_cnt0     out  CNT_W  grants to requester 0, saturating
//  gnt_cnt1     out  CNT_W  grants to requester 1, saturating
// BEHAVIOUR
//  Reset: iss_v=0, rsp_valid=0, rsp_id=0, rsp_rd=0, alu_* =0, gnt_cnt*=0, rr pointer=0.
//  Pipe control: wb_adv = !rsp_valid | rsp_ready; iss_adv = !iss_v | wb_adv.
//  reqN_ready = iss_adv & gnt[N]; at most one ready high per cycle; ready never
//   depends on its own valid (grant computed from both valids, then gated).
//  Grant: only one valid -> that one; both valid -> arbitration (see CONFIGURATION).
//  Accept at edge N: ISS <= {fnc3,fnc1,rs1,rs2,id}; ALU sees them in cycle N+1;
//   on wb_adv at edge N+1, WB <= {alu_rd,id}, rsp_valid=1. Latency 2 edges.
//  ISS moves to WB only when wb_adv; otherwise ISS and alu_* hold (stall, no loss).
//  rsp_valid falls when rsp_ready & !iss_v at edge; rsp_* stable while valid&!ready.
//  Back-to-back: one accept per cycle sustained while rsp_ready=1.
//  Counters: +1 on each accept of that requester; hold at 2^CNT_W-1.
//  rst mid-operation: ISS and WB contents dropped, no response emitted; counters cleared.
//  No reordering: responses leave in acceptance order.
// CONFIGURATION
//  ALU_ARB_RR_EN defined: round-robin; rr pointer names the preferred requester,
//   on each accept pointer <= ~granted id; pointer holds when nothing accepted.
//  ALU_ARB_RR_EN undefined: fixed priority, requester 0 always wins; rr pointer absent.
// TESTING
//  1 single op: req0 ADD rs1=0x8000_0001 rs2=0xFFFF_8002, rsp_ready=1 ->
//    req0_ready=1, two edges later rsp_valid=1 rsp_id=0 rsp_rd=0x7FFF_8003.
//  2 SUB/SRA via req1: fnc3=FNC_SRL_SRA fnc1=FNC2_SRA rs1=0x8000_0000 rs2=4 ->
//    rsp_id=1 rsp_rd=0xF800_0000; SUB 5-7 -> 0xFFFF_FFFE.
//  3 contention, both valid 6 cycles, ALU_ARB_RR_EN: grants alternate 0,1,0,1,0,1,
//    gnt_cnt0=gnt_cnt1=3; without macro: six grants to 0, req1_ready=0 throughout.
//  4 backpressure: rsp_ready=0 for 5 cycles with stream from req0 -> ISS+WB fill,
//    req0_ready=0 from 3rd cycle, rsp_rd held; release -> results in order, none lost.
//  5 reset mid-flight: rst=1 with iss_v=1 and rsp_valid=1 -> next cycle rsp_valid=0,
//    counters 0, no stale response after rst drops.
//  6 saturation: CNT_W=4, 20 req0 accepts -> gnt_cnt0=15.

Source files
------------

// File: rtl/alu_share_arb.sv
// Two-requester front end for one shared combinational RV32 ALU: ISS register feeds the ALU,
// WB register holds the tagged result. Define ALU_ARB_RR_EN for round-robin, else requester 0 wins.
module alu_share_arb #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_fnc3,
  input  logic             req0_fnc1,
  input  logic [XLEN-1:0]  req0_rs1,
  input  logic [XLEN-1:0]  req0_rs2,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_fnc3,
  input  logic             req1_fnc1,
  input  logic [XLEN-1:0]  req1_rs1,
  input  logic [XLEN-1:0]  req1_rs2,
  output logic [2:0]       alu_fnc3,
  output logic             alu_fnc1,
  output logic [XLEN-1:0]  alu_rs1,
  output logic [XLEN-1:0]  alu_rs2,
  input  logic [XLEN-1:0]  alu_rd,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [XLEN-1:0]  rsp_rd,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  logic             iss_v_q, iss_v_d;
  logic [2:0]       iss_fnc3_q, iss_fnc3_d;
  logic             iss_fnc1_q, iss_fnc1_d;
  logic [XLEN-1:0]  iss_rs1_q, iss_rs1_d;
  logic [XLEN-1:0]  iss_rs2_q, iss_rs2_d;
  logic             iss_id_q, iss_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [XLEN-1:0]  rsp_rd_q, rsp_rd_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic       wb_adv, iss_adv;
  logic [1:0] gnt;
  logic       acc0, acc1, acc_any;
  logic       pref1;

`ifdef ALU_ARB_RR_EN
  logic rr_q, rr_d;
  assign pref1 = rr_q;
  assign rr_d  = acc_any ? ~acc1 : rr_q;
`else
  assign pref1 = 1'b0;
`endif

  assign wb_adv  = !rsp_valid_q || rsp_ready;
  assign iss_adv = !iss_v_q || wb_adv;

  // With no one valid the preferred requester holds the grant, so exactly one ready can be high.
  always_comb begin
    gnt = 2'b01;
    if (req0_valid && (!req1_valid || !pref1)) gnt = 2'b01;
    else if (req1_valid)                       gnt = 2'b10;
    else if (pref1)                            gnt = 2'b10;
  end

  assign req0_ready = iss_adv && gnt[0];
  assign req1_ready = iss_adv && gnt[1];
  assign acc0       = req0_valid && req0_ready;
  assign acc1       = req1_valid && req1_ready;
  assign acc_any    = acc0 || acc1;

  always_comb begin
    iss_v_d     = iss_v_q;
    iss_fnc3_d  = iss_fnc3_q;
    iss_fnc1_d  = iss_fnc1_q;
    iss_rs1_d   = iss_rs1_q;
    iss_rs2_d   = iss_rs2_q;
    iss_id_d    = iss_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_rd_d    = rsp_rd_q;
    if (iss_adv) begin
      iss_v_d = acc_any;
      if (acc_any) begin
        iss_fnc3_d = acc1 ? req1_fnc3 : req0_fnc3;
        iss_fnc1_d = acc1 ? req1_fnc1 : req0_fnc1;
        iss_rs1_d  = acc1 ? req1_rs1  : req0_rs1;
        iss_rs2_d  = acc1 ? req1_rs2  : req0_rs2;
        iss_id_d   = acc1;
      end
    end
    // WB payload only changes when a new result lands, keeping rsp_* stable otherwise.
    if (wb_adv) begin
      rsp_valid_d = iss_v_q;
      if (iss_v_q) begin
        rsp_rd_d = alu_rd;
        rsp_id_d = iss_id_q;
      end
    end
  end

  assign cnt0_d = (acc0 && (cnt0_q != {CNT_W{1'b1}})) ? cnt0_q + CNT_W'(1) : cnt0_q;
  assign cnt1_d = (acc1 && (cnt1_q != {CNT_W{1'b1}})) ? cnt1_q + CNT_W'(1) : cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_v_q     <= 1'b0;
      iss_fnc3_q  <= '0;
      iss_fnc1_q  <= 1'b0;
      iss_rs1_q   <= '0;
      iss_rs2_q   <= '0;
      iss_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_rd_q    <= '0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
`ifdef ALU_ARB_RR_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      iss_v_q     <= iss_v_d;
      iss_fnc3_q  <= iss_fnc3_d;
      iss_fnc1_q  <= iss_fnc1_d;
      iss_rs1_q   <= iss_rs1_d;
      iss_rs2_q   <= iss_rs2_d;
      iss_id_q    <= iss_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rd_q    <= rsp_rd_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
`ifdef ALU_ARB_RR_EN
      rr_q        <= rr_d;
`endif
    end
  end

  assign alu_fnc3  = iss_fnc3_q;
  assign alu_fnc1  = iss_fnc1_q;
  assign alu_rs1   = iss_rs1_q;
  assign alu_rs2   = iss_rs2_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rd    = rsp_rd_q;
  assign gnt_cnt0  = cnt0_q;
  assign gnt_cnt1  = cnt1_q;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: vector table for single ops, hand sequences for
// contention, backpressure, reset mid-flight and counter saturation (CNT_W=4).
module tb_alu_share_arb;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req0_fnc1;
  logic [2:0]       req0_fnc3;
  logic [XLEN-1:0]  req0_rs1, req0_rs2;
  logic             req1_valid, req1_ready, req1_fnc1;
  logic [2:0]       req1_fnc3;
  logic [XLEN-1:0]  req1_rs1, req1_rs2;
  logic [2:0]       alu_fnc3;
  logic             alu_fnc1;
  logic [XLEN-1:0]  alu_rs1, alu_rs2, alu_rd;
  logic             rsp_valid, rsp_ready, rsp_id;
  logic [XLEN-1:0]  rsp_rd;
  logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

  int checks = 0;
  int errors = 0;

  logic [32:0] got_q[$];
  logic [32:0] exp_q[$];

  typedef struct {
    logic        id;
    logic [2:0]  f3;
    logic        f1;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rd;
  } vec_t;
  vec_t vecs[10];

  alu_share_arb #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fnc3(req0_fnc3),
    .req0_fnc1(req0_fnc1), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fnc3(req1_fnc3),
    .req1_fnc1(req1_fnc1), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
    .alu_fnc3(alu_fnc3), .alu_fnc1(alu_fnc1), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
    .alu_rd(alu_rd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_rd(rsp_rd),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  always #5 clk = ~clk;

  // The shared ALU itself (RV32 funct3 encodings, fnc1 = funct7[5]).
  always_comb begin
    case (alu_fnc3)
      3'd0:    alu_rd = alu_fnc1 ? alu_rs1 - alu_rs2 : alu_rs1 + alu_rs2;
      3'd1:    alu_rd = alu_rs1 << alu_rs2[4:0];
      3'd2:    alu_rd = {31'b0, ($signed(alu_rs1) < $signed(alu_rs2))};
      3'd3:    alu_rd = {31'b0, (alu_rs1 < alu_rs2)};
      3'd4:    alu_rd = alu_rs1 ^ alu_rs2;
      3'd5:    alu_rd = alu_fnc1 ? 32'($signed(alu_rs1) >>> alu_rs2[4:0]) : alu_rs1 >> alu_rs2[4:0];
      3'd6:    alu_rd = alu_rs1 | alu_rs2;
      default: alu_rd = alu_rs1 & alu_rs2;
    endcase
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      got_q.push_back({rsp_id, rsp_rd});
      $display("rsp id=%0d rd=%h", rsp_id, rsp_rd);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0; req0_fnc3 = 3'd0; req0_fnc1 = 1'b0; req0_rs1 = '0; req0_rs2 = '0;
    req1_valid = 1'b0; req1_fnc3 = 3'd0; req1_fnc1 = 1'b0; req1_rs1 = '0; req1_rs2 = '0;
  endtask

  task automatic drive(input logic id, input logic [2:0] f3, input logic f1,
                       input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      req1_valid = 1'b1; req1_fnc3 = f3; req1_fnc1 = f1; req1_rs1 = a; req1_rs2 = b;
    end else begin
      req0_valid = 1'b1; req0_fnc3 = f3; req0_fnc1 = f1; req0_rs1 = a; req0_rs2 = b;
    end
  endtask

  task automatic reset_dut();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic cmp_queues(input string name);
    chk({name, "_count"}, 33'(got_q.size()), 33'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({name, "_order"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    vecs[0] = '{1'b0, 3'd0, 1'b0, 32'h8000_0001, 32'hFFFF_8002, 32'h7FFF_8003};
    vecs[1] = '{1'b1, 3'd5, 1'b1, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000};
    vecs[2] = '{1'b1, 3'd0, 1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE};
    vecs[3] = '{1'b0, 3'd4, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00};
    vecs[4] = '{1'b0, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[5] = '{1'b1, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[6] = '{1'b0, 3'd1, 1'b0, 32'h0000_0001, 32'h0000_003F, 32'h8000_0000};
    vecs[7] = '{1'b1, 3'd5, 1'b0, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000};
    vecs[8] = '{1'b0, 3'd7, 1'b0, 32'h1234_5678, 32'h0000_FFFF, 32'h0000_5678};
    vecs[9] = '{1'b1, 3'd6, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678};

    rsp_ready = 1'b1;
    idle();
    rst = 1'b1;
    step();
    step();
    chk("rst_rsp_valid", 33'(rsp_valid), 33'd0);
    chk("rst_rsp_id",    33'(rsp_id),    33'd0);
    chk("rst_rsp_rd",    33'(rsp_rd),    33'd0);
    chk("rst_alu_rs1",   33'(alu_rs1),   33'd0);
    chk("rst_alu_fnc3",  33'(alu_fnc3),  33'd0);
    chk("rst_gnt_cnt0",  33'(gnt_cnt0),  33'd0);
    chk("rst_gnt_cnt1",  33'(gnt_cnt1),  33'd0);
    rst = 1'b0;

    // Single operations, latency two edges.
    for (int i = 0; i < 10; i++) begin
      idle();
      drive(vecs[i].id, vecs[i].f3, vecs[i].f1, vecs[i].a, vecs[i].b);
      #1;
      chk("vec_ready_own",   33'(vecs[i].id ? req1_ready : req0_ready), 33'd1);
      chk("vec_ready_other", 33'(vecs[i].id ? req0_ready : req1_ready), 33'd0);
      step();
      idle();
      chk("vec_rsp_early", 33'(rsp_valid), 33'd0);
      step();
      chk("vec_rsp_valid", 33'(rsp_valid), 33'd1);
      chk("vec_rsp_id",    33'(rsp_id),    33'(vecs[i].id));
      chk("vec_rsp_rd",    33'(rsp_rd),    33'(vecs[i].rd));
      $display("vec %0d id=%0d fnc3=%0d fnc1=%0d rd=%h", i, vecs[i].id, vecs[i].f3, vecs[i].f1, rsp_rd);
      step();
    end

    // Contention: both requesters valid for six cycles.
    reset_dut();
    begin
      int n0, n1, w;
      n0 = 0; n1 = 0;
      for (int k = 0; k < 6; k++) begin
`ifdef ALU_ARB_RR_EN
        w = k % 2;
`else
        w = 0;
`endif
        drive(1'b0, 3'd0, 1'b0, 32'h1000 + 32'(n0), 32'd0);
        drive(1'b1, 3'd0, 1'b0, 32'h2000 + 32'(n1), 32'd0);
        #1;
        chk("cont_ready0", 33'(req0_ready), 33'(w == 0));
        chk("cont_ready1", 33'(req1_ready), 33'(w == 1));
        if (w == 0) begin exp_q.push_back({1'b0, 32'h1000 + 32'(n0)}); n0++; end
        else        begin exp_q.push_back({1'b1, 32'h2000 + 32'(n1)}); n1++; end
        step();
      end
      idle();
      repeat (4) step();
`ifdef ALU_ARB_RR_EN
      chk("cont_cnt0", 33'(gnt_cnt0), 33'd3);
      chk("cont_cnt1", 33'(gnt_cnt1), 33'd3);
`else
      chk("cont_cnt0", 33'(gnt_cnt0), 33'd6);
      chk("cont_cnt1", 33'(gnt_cnt1), 33'd0);
`endif
      cmp_queues("cont");
    end

    // Backpressure: consumer stalls for five cycles, then releases.
    reset_dut();
    rsp_ready = 1'b0;
    begin
      int n;
      logic exp_rdy;
      n = 0;
      for (int k = 1; k <= 8; k++) begin
        if (k == 6) rsp_ready = 1'b1;
        drive(1'b0, 3'd0, 1'b0, 32'h40 + 32'(n), 32'd0);
        #1;
        exp_rdy = (k <= 2) || (k >= 6);
        chk("bp_ready0", 33'(req0_ready), 33'(exp_rdy));
        if (k >= 3 && k <= 5) begin
          chk("bp_hold_valid", 33'(rsp_valid), 33'd1);
          chk("bp_hold_rd",    33'(rsp_rd),    33'h40);
        end
        if (exp_rdy) begin exp_q.push_back({1'b0, 32'h40 + 32'(n)}); n++; end
        step();
      end
      idle();
      repeat (5) step();
      cmp_queues("bp");
    end

    // Reset while ISS and WB both hold operations.
    reset_dut();
    rsp_ready = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 32'h77, 32'd0);
    step();
    drive(1'b0, 3'd0, 1'b0, 32'h78, 32'd0);
    step();
    idle();
    #1;
    chk("mid_pre_valid", 33'(rsp_valid), 33'd1);
    rst = 1'b1;
    step();
    chk("mid_rsp_valid", 33'(rsp_valid), 33'd0);
    chk("mid_gnt_cnt0",  33'(gnt_cnt0),  33'd0);
    chk("mid_alu_rs1",   33'(alu_rs1),   33'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (4) step();
    chk("mid_no_stale", 33'(got_q.size()), 33'd0);

    // Saturation of a 4-bit grant counter.
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 3'd0, 1'b0, 32'(k), 32'd0);
      #1;
      if (k == 10) chk("sat_cnt_10", 33'(gnt_cnt0), 33'd10);
      if (k == 15) chk("sat_cnt_15", 33'(gnt_cnt0), 33'd15);
      step();
    end
    idle();
    repeat (3) step();
    chk("sat_cnt0", 33'(gnt_cnt0), 33'd15);
    chk("sat_cnt1", 33'(gnt_cnt1), 33'd0);
    chk("sat_rsp_count", 33'(got_q.size()), 33'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
